// File: rtl/ap_line_cached.sv
// Data-pointer line: address pointer, cell RAM and a write-back cell register with valid/dirty tracking.
// Latency: WRITE/NOP 0 busy cycles; steps n (+1 store or +2 load); READ 2; FLUSH 1; CLEAR 2**ADDR_W.
// Backpressure: CmdReady is high only in IDLE; one command in flight, fields captured on the accept edge.
module ap_line_cached #(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 8,
   parameter int COUNT_W = 8
) (
   input  logic               Clk,
   input  logic               Rst,
   input  logic               CmdValid,
   output logic               CmdReady,
   input  logic [2:0]         CmdOp,
   input  logic               CmdReverse,
   input  logic [COUNT_W-1:0] CmdCount,
   input  logic [DATA_W-1:0]  DataIn,
   output logic [ADDR_W-1:0]  ApAddr,
   output logic [DATA_W-1:0]  DataOut,
   output logic               DataValid,
   output logic               DataDirty,
   output logic               DataZero
);

   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [2:0] OP_AP    = 3'b001;
   localparam logic [2:0] OP_DATA  = 3'b010;
   localparam logic [2:0] OP_WRITE = 3'b011;
   localparam logic [2:0] OP_READ  = 3'b100;
   localparam logic [2:0] OP_FLUSH = 3'b101;
   localparam logic [2:0] OP_CLEAR = 3'b110;

   typedef enum logic [2:0] {
      IDLE, LOAD, LOAD_WAIT, DATA_CNT, STORE, AP_CNT, CLR
   } state_t;

   state_t               state;
   logic [2:0]           opReg;
   logic                 revReg;
   logic [COUNT_W-1:0]   remain;
   logic [ADDR_W-1:0]    clrAddr;
   logic [ADDR_W-1:0]    apReg;
   logic [DATA_W-1:0]    dataReg;
   logic                 validReg;
   logic                 dirtyReg;
   logic                 outOfRst;

   logic [DATA_W-1:0]    mem [0:DEPTH-1];
   logic [DATA_W-1:0]    ramQ;
   logic                 ramWe;
   logic [ADDR_W-1:0]    ramAddr;
   logic [DATA_W-1:0]    ramWd;

   // RAM write comes only from STORE (write-back) or CLR (zero fill); a reset forces IDLE so no write is half-done
   assign ramWe   = (state == STORE) || (state == CLR);
   assign ramAddr = (state == CLR) ? clrAddr : apReg;
   assign ramWd   = (state == CLR) ? '0 : dataReg;

   assign CmdReady  = (state == IDLE) && outOfRst;
   assign ApAddr    = apReg;
   assign DataOut   = dataReg;
   assign DataValid = validReg;
   assign DataDirty = dirtyReg;
   assign DataZero  = validReg && (dataReg == '0);

   // Single-port cell RAM: synchronous write, registered read of the current pointer (1-cycle latency)
   always_ff @(posedge Clk) begin
      if (ramWe) begin
         mem[ramAddr] <= ramWd;
      end
      ramQ <= mem[apReg];
   end

   // Command FSM: accepts in IDLE, sequences load / store / step / clear, owns pointer and cell register
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state    <= IDLE;
         opReg    <= '0;
         revReg   <= 1'b0;
         remain   <= '0;
         clrAddr  <= '0;
         apReg    <= '0;
         dataReg  <= '0;
         validReg <= 1'b0;
         dirtyReg <= 1'b0;
         outOfRst <= 1'b0;
      end else begin
         outOfRst <= 1'b1;
         case (state)
            IDLE: begin
               if (CmdValid && outOfRst) begin
                  opReg  <= CmdOp;
                  revReg <= CmdReverse;
                  remain <= CmdCount;
                  case (CmdOp)
                     // the pointer never moves while the cell is dirty, so write back first
                     OP_AP: begin
                        if (CmdCount != '0) begin
                           state <= dirtyReg ? STORE : AP_CNT;
                        end
                     end
                     OP_DATA: begin
                        if (CmdCount != '0) begin
                           state <= validReg ? DATA_CNT : LOAD;
                        end
                     end
                     OP_WRITE: begin
                        dataReg  <= DataIn;
                        validReg <= 1'b1;
                        dirtyReg <= 1'b1;
                     end
                     OP_READ: begin
                        if (!validReg) begin
                           state <= LOAD;
                        end
                     end
                     OP_FLUSH: begin
                        if (dirtyReg) begin
                           state <= STORE;
                        end
                     end
                     OP_CLEAR: begin
                        clrAddr <= '0;
                        state   <= CLR;
                     end
                     default: ;
                  endcase
               end
            end
            LOAD: begin
               state <= LOAD_WAIT;
            end
            LOAD_WAIT: begin
               dataReg  <= ramQ;
               validReg <= 1'b1;
               dirtyReg <= 1'b0;
               state    <= (opReg == OP_DATA) ? DATA_CNT : IDLE;
            end
            DATA_CNT: begin
               dataReg  <= revReg ? dataReg - DATA_W'(1) : dataReg + DATA_W'(1);
               dirtyReg <= 1'b1;
               if (remain == COUNT_W'(1)) begin
                  state <= IDLE;
               end else begin
                  remain <= remain - COUNT_W'(1);
               end
            end
            STORE: begin
               dirtyReg <= 1'b0;
               state    <= (opReg == OP_AP) ? AP_CNT : IDLE;
            end
            AP_CNT: begin
               apReg    <= revReg ? apReg - ADDR_W'(1) : apReg + ADDR_W'(1);
               validReg <= 1'b0;
               if (remain == COUNT_W'(1)) begin
                  state <= IDLE;
               end else begin
                  remain <= remain - COUNT_W'(1);
               end
            end
            CLR: begin
               // pending dirty data is discarded; the cell register ends up mirroring the zeroed cell 0
               if (clrAddr == ADDR_W'(DEPTH - 1)) begin
                  apReg    <= '0;
                  dataReg  <= '0;
                  validReg <= 1'b1;
                  dirtyReg <= 1'b0;
                  state    <= IDLE;
               end else begin
                  clrAddr <= clrAddr + ADDR_W'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
